pipelined_divmod_unit: RTL and testbench
========================================

// Module: pipelined_divmod_unit
// PURPOSE
//  Parametrised, pipelined unsigned non-restoring divider/modulo unit. Accepts one division per cycle.
//  Returns either the quotient or the sign-corrected remainder, selected per operation.
//  Adds valid/ready backpressure, a configurable number of rows per pipeline stage, a sideband tag,
//  and divide-by-zero / quotient-overflow flags. Sits between the datapath issue logic and the result bus.
// PARAMETERS
//  DIVIDEND_W      32  dividend width in bits; must be > DIVISOR_W
//  DIVISOR_W       16  divisor width in bits; must be >= 2
//  ROWS_PER_STAGE   4  non-restoring rows evaluated combinationally between pipeline registers (1..QUOT_W)
//  TAG_W            4  sideband tag width, carried unchanged alongside the operation
//  Derived: QUOT_W = DIVIDEND_W-DIVISOR_W+1; STAGES = ceil(QUOT_W/ROWS_PER_STAGE); LATENCY = STAGES+1
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           asynchronous, active-high reset
//  in_valid     in   1           operation present on in_* this cycle
//  in_ready     out  1           unit accepts an operation this cycle
//  in_mode      in   1           0 = quotient, 1 = remainder
//  in_dividend  in   DIVIDEND_W  unsigned dividend
//  in_divisor   in   DIVISOR_W   unsigned divisor
//  in_tag       in   TAG_W       sideband tag
//  out_valid    out  1           result present on out_* this cycle
//  out_ready    in   1           consumer takes the result this cycle
//  out_result   out  DIVIDEND_W  quotient or remainder, zero-extended
//  out_tag      out  TAG_W       tag of the operation that produced out_result
//  out_div0     out  1           divisor was zero
//  out_ovf      out  1           quotient does not fit in QUOT_W bits (divisor != 0)
// BEHAVIOUR
//  - Reset: out_valid, every stage valid bit, out_result, out_tag, out_div0 and out_ovf go to 0.
//    Any operation in flight is discarded. in_ready = 1 from the first cycle after reset is released.
//  - Handshake: adv = out_ready | ~out_valid; in_ready = adv (combinational).
//    An input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
//  - Stall: when adv = 0, every pipeline register, including the output register, holds its value.
//    Bubbles are not compressed.
//  - Latency: with adv = 1 throughout, an operation accepted at edge N appears on out_* after edge N+LATENCY.
//    Defaults give QUOT_W = 17, STAGES = 5, LATENCY = 6. Throughput is 1 operation per cycle.
//  - Datapath: QUOT_W non-restoring rows.
//    Row 0 always subtracts the divisor from dividend[DIVIDEND_W-1:QUOT_W-1].
//    Each later row shifts in the next dividend bit and subtracts if the previous partial remainder is
//    non-negative, otherwise adds. q bit = ~sign of the row result. Partial remainders are DIVISOR_W+1 bits
//    wide, so sign and magnitude never alias.
//  - Each stage register carries: partial remainder, quotient bits so far, remaining dividend bits,
//    divisor, mode, tag, div0, ovf and valid.
//  - Final correction: if the last partial remainder is negative, add the divisor once.
//    The remainder is then always in [0, divisor).
//  - out_result is {0, quotient[QUOT_W-1:0]} when mode = 0, and {0, remainder[DIVISOR_W-1:0]} when mode = 1.
//  - out_div0 is set when in_divisor == 0. Then quotient = all ones (QUOT_W bits), remainder = 0,
//    and out_ovf = 0.
//  - out_ovf is set when divisor != 0 and dividend[DIVIDEND_W-1:QUOT_W] >= divisor, evaluated at input.
//    Then quotient = all ones (QUOT_W bits) and remainder = 0.
//  - Simultaneous accept and drain in the same cycle is legal and keeps full throughput.
//  - in_valid = 0 while in_ready = 1 inserts a bubble (stage valid = 0). Data under valid = 0 is don't-care.
// TESTING
//  1 Single op, mode 0: 1000 / 7 -> out_result = 142, out_div0 = 0, out_ovf = 0,
//    out_valid exactly LATENCY cycles after acceptance.
//  2 Mode 1, negative final partial remainder: 1000 mod 7 -> 6; 0xFFFFFFFF mod 0xFFFF -> 0;
//    0xFFFFFFFF / 0xFFFF -> 0x10001.
//  3 Divisor 0, dividend 0x1234 -> out_div0 = 1, quotient 0x1FFFF, remainder 0, tag preserved.
//    Dividend 0x00020000 / 1 -> out_ovf = 1, quotient 0x1FFFF.
//  4 Back-to-back stream of 200 random ops with random mixed modes and tags, with out_ready held at 1:
//    1 result per cycle, in order, each matching a reference model (a / b, a % b).
//  5 Backpressure: stream ops while toggling out_ready randomly at 50%. Required: no loss or duplication,
//    out_* stable while out_valid & ~out_ready, in_ready == (out_ready | ~out_valid).
//  6 Assert reset with 4 ops in flight -> out_valid = 0 immediately (async).
//    After release, no stale results; a new op 81 / 9 returns 9.

Source files
------------

// File: rtl/pipelined_divmod_unit.sv
// rtl/pipelined_divmod_unit.sv - pipelined unsigned non-restoring divide/modulo unit with valid/ready handshake
module pipelined_divmod_unit #(
  parameter int DIVIDEND_W     = 32,
  parameter int DIVISOR_W      = 16,
  parameter int ROWS_PER_STAGE = 4,
  parameter int TAG_W          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_result,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_div0,
  output logic                  out_ovf
);

  localparam int QUOT_W = DIVIDEND_W - DIVISOR_W + 1;
  localparam int STAGES = (QUOT_W + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int PR_W   = DIVISOR_W + 1;
  localparam int HI_W   = DIVIDEND_W - QUOT_W;

  // Partial remainder is one bit wider than the divisor so its sign never aliases with magnitude.
  typedef struct packed {
    logic [PR_W-1:0]   rem;
    logic [QUOT_W-1:0] quo;
    logic [QUOT_W-1:0] dvd;
  } row_state_t;

  // Apply up to ROWS_PER_STAGE non-restoring rows; rows past QUOT_W are pass-through.
  function automatic row_state_t run_rows(input row_state_t st, input logic [DIVISOR_W-1:0] dsr,
                                          input int first_row);
    row_state_t      t;
    logic [PR_W-1:0] sh;
    t  = st;
    sh = '0;
    for (int j = 0; j < ROWS_PER_STAGE; j++) begin
      if (first_row + j < QUOT_W) begin
        sh = {t.rem[PR_W-2:0], t.dvd[QUOT_W-1]};
        if (t.rem[PR_W-1]) t.rem = sh + {1'b0, dsr};
        else               t.rem = sh - {1'b0, dsr};
        t.quo = {t.quo[QUOT_W-2:0], ~t.rem[PR_W-1]};
        t.dvd = {t.dvd[QUOT_W-2:0], 1'b0};
      end
    end
    return t;
  endfunction

  // Stage 0 holds the accepted operation; stages 1..STAGES hold results of successive row groups.
  row_state_t           st_q   [0:STAGES];
  row_state_t           st_d   [1:STAGES];
  logic [DIVISOR_W-1:0] dsr_q  [0:STAGES];
  logic                 mode_q [0:STAGES];
  logic [TAG_W-1:0]     tag_q  [0:STAGES];
  logic                 div0_q [0:STAGES];
  logic                 ovf_q  [0:STAGES];
  logic                 vld_q  [0:STAGES];

  logic                  out_valid_q;
  logic [DIVIDEND_W-1:0] out_result_q;
  logic [TAG_W-1:0]      out_tag_q;
  logic                  out_div0_q;
  logic                  out_ovf_q;

  logic                  adv;
  logic [HI_W-1:0]       in_hi;
  logic                  in_div0;
  logic                  in_ovf;
  row_state_t            st0_d;
  logic [DIVISOR_W-1:0]  rem_fix;
  logic [QUOT_W-1:0]     quo_fin;
  logic [DIVISOR_W-1:0]  rem_fin;
  logic [DIVIDEND_W-1:0] out_result_d;

  // Whole pipeline advances together; bubbles are not compressed.
  assign adv      = out_ready | ~out_valid_q;
  assign in_ready = adv;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_div0   = out_div0_q;
  assign out_ovf    = out_ovf_q;

  // Input preparation: flag checks and seeding the remainder with the dividend bits above the first row.
  always_comb begin
    in_hi     = in_dividend[DIVIDEND_W-1:QUOT_W];
    in_div0   = (in_divisor == '0);
    in_ovf    = ~in_div0 & ({1'b0, in_hi} >= in_divisor);
    st0_d.rem = {2'b00, in_hi};
    st0_d.quo = '0;
    st0_d.dvd = in_dividend[QUOT_W-1:0];
  end

  // Row groups between pipeline registers.
  always_comb begin
    for (int s = 1; s <= STAGES; s++) begin
      st_d[s] = run_rows(st_q[s-1], dsr_q[s-1], (s - 1) * ROWS_PER_STAGE);
    end
  end

  // Final correction, exceptional-case override and mode selection.
  always_comb begin
    rem_fix = st_q[STAGES].rem[DIVISOR_W-1:0]
            + (st_q[STAGES].rem[PR_W-1] ? dsr_q[STAGES] : '0);
    quo_fin = st_q[STAGES].quo;
    rem_fin = rem_fix;
    if (div0_q[STAGES] | ovf_q[STAGES]) begin
      quo_fin = '1;
      rem_fin = '0;
    end
    if (mode_q[STAGES]) out_result_d = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, rem_fin};
    else                out_result_d = {{(DIVIDEND_W-QUOT_W){1'b0}}, quo_fin};
  end

  // Pipeline and output registers: cleared on reset, all hold when the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s <= STAGES; s++) begin
        st_q[s]   <= '0;
        dsr_q[s]  <= '0;
        mode_q[s] <= 1'b0;
        tag_q[s]  <= '0;
        div0_q[s] <= 1'b0;
        ovf_q[s]  <= 1'b0;
        vld_q[s]  <= 1'b0;
      end
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_div0_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else if (adv) begin
      st_q[0]   <= st0_d;
      dsr_q[0]  <= in_divisor;
      mode_q[0] <= in_mode;
      tag_q[0]  <= in_tag;
      div0_q[0] <= in_div0;
      ovf_q[0]  <= in_ovf;
      vld_q[0]  <= in_valid;
      for (int s = 1; s <= STAGES; s++) begin
        st_q[s]   <= st_d[s];
        dsr_q[s]  <= dsr_q[s-1];
        mode_q[s] <= mode_q[s-1];
        tag_q[s]  <= tag_q[s-1];
        div0_q[s] <= div0_q[s-1];
        ovf_q[s]  <= ovf_q[s-1];
        vld_q[s]  <= vld_q[s-1];
      end
      out_valid_q  <= vld_q[STAGES];
      out_result_q <= out_result_d;
      out_tag_q    <= tag_q[STAGES];
      out_div0_q   <= div0_q[STAGES];
      out_ovf_q    <= ovf_q[STAGES];
    end
  end

endmodule

// File: tb/tb_pipelined_divmod_unit.sv
// tb/tb_pipelined_divmod_unit.sv - scoreboard bench for pipelined_divmod_unit
module tb_pipelined_divmod_unit;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int TAG_W      = 4;
  localparam int QUOT_W     = 17;
  localparam int LATENCY    = 6;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [DIVIDEND_W-1:0] in_dividend;
  logic [DIVISOR_W-1:0]  in_divisor;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] out_result;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_div0;
  logic                  out_ovf;

  pipelined_divmod_unit #(
    .DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W), .ROWS_PER_STAGE(4), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_div0(out_div0), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DIVIDEND_W-1:0] res;
    logic [TAG_W-1:0]      tag;
    logic                  div0;
    logic                  ovf;
    int                    acc_cyc;
    bit                    lat_chk;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  bit   lat_mode   = 1'b0;
  bit   rnd_ready  = 1'b0;

  bit                    prev_stall = 1'b0;
  logic [DIVIDEND_W-1:0] prev_res;
  logic [TAG_W-1:0]      prev_tag;
  logic                  prev_div0;
  logic                  prev_ovf;

  // Reference: plain integer division with the exceptional-case rules.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input logic m,
                                 input logic [3:0] t);
    exp_t            e;
    longint unsigned q, r;
    e.div0 = 1'b0;
    e.ovf  = 1'b0;
    if (b == 16'd0) begin
      e.div0 = 1'b1;
      q = (64'd1 << QUOT_W) - 1;
      r = 0;
    end else begin
      q = longint'(a) / longint'(b);
      r = longint'(a) % longint'(b);
      if (q >= (64'd1 << QUOT_W)) begin
        e.ovf = 1'b1;
        q = (64'd1 << QUOT_W) - 1;
        r = 0;
      end
    end
    e.res     = m ? r[31:0] : q[31:0];
    e.tag     = t;
    e.acc_cyc = 0;
    e.lat_chk = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Monitor: handshake rule, stall stability, scoreboard pop and push at the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (out_ready | ~out_valid)});
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_result", {32'd0, out_result}, {32'd0, prev_res});
        chk("stall_tag_flags", {58'd0, out_tag, out_div0, out_ovf},
            {58'd0, prev_tag, prev_div0, prev_ovf});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", {32'd0, out_result}, {32'd0, e.res});
          chk("tag", {60'd0, out_tag}, {60'd0, e.tag});
          chk("div0_ovf", {62'd0, out_div0, out_ovf}, {62'd0, e.div0, e.ovf});
          if (e.lat_chk) chk("latency", 64'(cyc - e.acc_cyc), 64'(LATENCY));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
      prev_div0  = out_div0;
      prev_ovf   = out_ovf;
      if (in_valid && in_ready) begin
        e         = model(in_dividend, in_divisor, in_mode, in_tag);
        e.acc_cyc = cyc + 1;
        e.lat_chk = lat_mode;
        sb.push_back(e);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge on which the op transferred.
  task automatic send(input logic [31:0] a, input logic [15:0] b, input logic m, input logic [3:0] t);
    int guard;
    guard       = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_mode     = m;
    in_tag      = t;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while (sb.size() != 0 && g < budget) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic rnd_op(output logic [31:0] a, output logic [15:0] b);
    case ($urandom_range(0, 3))
      0:       a = $urandom;
      1:       a = $urandom >> $urandom_range(8, 20);
      2:       a = $urandom_range(0, 255);
      default: a = $urandom >> 1;
    endcase
    case ($urandom_range(0, 7))
      0:       b = 16'd0;
      1:       b = 16'd1;
      2:       b = 16'hFFFF;
      default: b = 16'($urandom_range(1, 65535));
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [15:0] b;
    int          guard;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_mode     = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", {32'd0, out_result}, 64'd0);
    chk("reset_tag_flags", {58'd0, out_tag, out_div0, out_ovf}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Single op latency, remainder-correction cases, exceptional flags.
    lat_mode = 1'b1;
    send(32'd1000, 16'd7, 1'b0, 4'd5);
    drain(50);
    send(32'd1000, 16'd7, 1'b1, 4'd1);
    send(32'hFFFFFFFF, 16'hFFFF, 1'b1, 4'd2);
    send(32'hFFFFFFFF, 16'hFFFF, 1'b0, 4'd3);
    send(32'h1234, 16'd0, 1'b0, 4'hA);
    send(32'h1234, 16'd0, 1'b1, 4'hB);
    send(32'h00020000, 16'd1, 1'b0, 4'hC);
    drain(50);

    // Back-to-back random stream with the consumer always ready.
    for (int i = 0; i < 200; i++) begin
      rnd_op(a, b);
      send(a, b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    drain(50);

    // Random backpressure with occasional input bubbles.
    lat_mode  = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rnd_op(a, b);
      send(a, b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain(2000);
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Reset with operations in flight and a stalled output.
    for (int i = 0; i < 4; i++) send(32'd500 + 32'(i), 16'd3, 1'b0, 4'(i));
    out_ready = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_stale_output", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    lat_mode = 1'b1;
    send(32'd81, 16'd9, 1'b0, 4'd7);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
